// File: rtl/dip_pkg.sv
// Shared types and sizing helpers for the DIP-switch debounce block.
package dip_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } chan_state_t;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

   // Counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
   function automatic int calc_cnt_w(input int cycles);
      return (cycles < 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/dip_debounce_channel.sv
// One switch bit: 2-flop synchroniser, stability counter, accept FSM,
// registered rise/fall pulses and a sticky change flag.
//
// state | meaning
// IDLE  | sync2 matches dip_out, counter parked at 0
// COUNT | sync2 differs from dip_out, counting consecutive stable cycles
module dip_debounce_channel
   import dip_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = calc_cnt_w(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic reset,
   input  logic dip_raw,
   input  logic clear_change,
   output logic dip_out,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic change_flag
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             r_sync1;
   logic             r_sync2;
   chan_state_t      r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_dip_out;
   logic             r_rise;
   logic             r_fall;
   logic             r_change;

   logic w_differ;
   logic w_accept;

   assign w_differ = r_sync2 ^ r_dip_out;
   assign w_accept = (r_state == COUNT) && w_differ && (r_cnt == CNT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_dip_out <= 1'b0;
         r_rise    <= 1'b0;
         r_fall    <= 1'b0;
         r_change  <= 1'b0;
      end else begin
         r_sync1 <= dip_raw;
         r_sync2 <= r_sync1;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;

         case (r_state)
            IDLE: begin
               if (w_differ) begin
                  r_state <= COUNT;
                  r_cnt   <= CNT_ONE;
               end else begin
                  r_cnt <= '0;
               end
            end
            COUNT: begin
               if (!w_differ) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_dip_out <= r_sync2;
                  r_rise    <= r_sync2;
                  r_fall    <= ~r_sync2;
                  r_cnt     <= '0;
                  r_state   <= IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
         endcase

         // A transition accepted on the clearing edge must still be seen.
         if (w_accept) begin
            r_change <= 1'b1;
         end else if (clear_change) begin
            r_change <= 1'b0;
         end
      end
   end

   assign dip_out     = r_dip_out;
   assign rise_pulse  = r_rise;
   assign fall_pulse  = r_fall;
   assign change_flag = r_change;

endmodule

// File: rtl/dip_debounce.sv
// DIP-switch conditioning ahead of the PIO in_port: WIDTH independent
// debounce channels sharing one change-flag clear.
module dip_debounce
   import dip_pkg::*;
#(
   parameter int WIDTH           = 1,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] dip_raw,
   input  logic             clear_change,
   output logic [WIDTH-1:0] dip_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic [WIDTH-1:0] change_flag
);

   localparam int CNT_W = calc_cnt_w(DEBOUNCE_CYCLES);

   for (genvar g = 0; g < WIDTH; g++) begin : g_chan
      dip_debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_chan (
         .clk          (clk),
         .reset        (reset),
         .dip_raw      (dip_raw[g]),
         .clear_change (clear_change),
         .dip_out      (dip_out[g]),
         .rise_pulse   (rise_pulse[g]),
         .fall_pulse   (fall_pulse[g]),
         .change_flag  (change_flag[g])
      );
   end

endmodule
